key_pad_debounce: RTL
=====================

Name: key_pad_debounce

Overview:
- Parametrised N-channel debouncer for active-low push-buttons; successor to the fixed four-direction key input block.
- Per key: synchroniser, debounce counter, clean level, one-cycle press/release pulses, optional hold-to-repeat (auto-repeat) pulses.
- A merged event flag plus an encoded key index feed game/menu logic directly.
- Sits between the board pins and the game controller FSMs.

Parameters:
- N_KEYS, 4, number of key channels (>=1).
- CNT_MAX, 999_999, debounce terminal count: raw level must be stable CNT_MAX+1 cycles (20 ms at 50 MHz).
- REPEAT_DLY, 24_999_999, cycles-1 from press pulse to first repeat pulse (500 ms).
- REPEAT_PER, 4_999_999, cycles-1 between subsequent repeat pulses (100 ms).
- CNT_W, 25, counter width; must hold max(CNT_MAX, REPEAT_DLY, REPEAT_PER).
- IDX_W, $clog2(N_KEYS) (min 1), width of key_code.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  asynchronous, active-low reset.
- key_n  in  N_KEYS  raw key inputs; 0 = pressed; asynchronous to sys_clk.
- repeat_en  in  1  1 = auto-repeat enabled (quasi-static).
- key_state  out  N_KEYS  debounced level; 1 = pressed.
- key_press  out  N_KEYS  one-cycle pulse on accepted press.
- key_release  out  N_KEYS  one-cycle pulse on accepted release.
- key_repeat  out  N_KEYS  one-cycle auto-repeat pulse.
- key_flag  out  1  OR over all channels of (key_press | key_repeat).
- key_code  out  IDX_W  lowest index i with key_press[i] | key_repeat[i]; valid only when key_flag = 1, else 0.

Behaviour:
- Reset (async): sync flops = 1; key_state = 0; all pulses, key_flag, key_code = 0; all counters = 0; repeat FSMs = IDLE.
- Sync: 2-flop per key. s = inverted sync output (1 = pressed).
- Debounce, per channel:
  - cnt clears whenever s == key_state; otherwise it increments.
  - When cnt == CNT_MAX and s != key_state: key_state <= s, cnt <= 0, and key_press (s = 1) or key_release (s = 0) pulses that same edge.
  - Any single-cycle glitch back to key_state restarts the count.
  - Latency: key_state changes on the (CNT_MAX+3)th rising edge after the first edge that samples the new key_n level.
- Repeat FSM, per channel, states IDLE, DELAY, REPEAT, with counter rcnt:
  - IDLE -> DELAY (rcnt = 0) on the press-pulse edge if repeat_en = 1.
  - DELAY: rcnt++. At rcnt == REPEAT_DLY: key_repeat pulses, rcnt = 0, go to REPEAT.
  - REPEAT: rcnt++. At rcnt == REPEAT_PER: key_repeat pulses, rcnt = 0.
  - First repeat follows the press pulse by REPEAT_DLY+1 cycles; later repeats are REPEAT_PER+1 cycles apart.
  - Release pulse or repeat_en = 0 -> IDLE on that edge. No key_repeat pulses that cycle.
  - Release-pulse edge coinciding with a terminal count: release wins, no key_repeat.
- key_press and key_repeat are never both set on the same channel in one cycle.
- Merge: key_flag and key_code are registered from the same-cycle pulse vectors, so they lag the pulses by one cycle.
  - Simultaneous events: lowest index wins key_code; every channel still appears in its own pulse vector.
- All outputs registered; no combinational path from key_n.
- Mid-operation reset returns everything to reset values immediately. A key held through reset release produces a fresh press after CNT_MAX+3 cycles.
- N_KEYS = 1: key_code is constant 0.

Decomposition:
- Package key_pkg:
  - repeat FSM state enum (IDLE, DELAY, REPEAT);
  - default timing constants for 50 MHz;
  - scaled simulation constants (CNT_MAX = 24, REPEAT_DLY = 99, REPEAT_PER = 39).
- Sub-module key_chan: one channel (sync, debounce, repeat FSM), instantiated N_KEYS times by generate.
- Top: generate loop, plus priority encoder / OR merge and its output register.

Test Plan (scaled: N_KEYS = 4, CNT_MAX = 24, REPEAT_DLY = 99, REPEAT_PER = 39):
- Clean press: key_n[0] low at cycle 0, held 30 cycles -> key_state[0] rises and key_press[0] pulses at edge 27; key_flag = 1, key_code = 0 at edge 28.
- Bounce: key_n[2] toggles randomly for 200 cycles, never stable 25 cycles, then low -> exactly one key_press[2], 27 edges after the final stable low; no spurious pulses during the bounce.
- Auto-repeat: repeat_en = 1, hold key 1 for 300 cycles -> key_repeat[1] at press + 100, +140, +180, ...; key_code = 1 one cycle after each; key_release[1] after letting go, with no trailing repeat.
- repeat_en = 0: same hold -> only key_press and key_release, zero key_repeat pulses.
- Simultaneous: keys 3 and 1 pressed on the same edge -> key_press = 4'b1010, key_code = 1, key_flag high for exactly one cycle.
- Reset mid-DELAY: assert sys_rst_n low while key 0 is held -> outputs 0 immediately; after reset release, key_press[0] again at edge 27 with no repeat before press + 100.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and timing constants for the key pad debouncer.
package key_pkg;

  // Per-channel auto-repeat state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Board timing at 50 MHz: 20 ms debounce, 500 ms first repeat, 100 ms repeat period.
  localparam int CNT_MAX_DEF    = 999_999;
  localparam int REPEAT_DLY_DEF = 24_999_999;
  localparam int REPEAT_PER_DEF = 4_999_999;
  localparam int CNT_W_DEF      = 25;

  // Scaled-down timing so simulations finish in a few thousand cycles.
  localparam int CNT_MAX_SIM    = 24;
  localparam int REPEAT_DLY_SIM = 99;
  localparam int REPEAT_PER_SIM = 39;

  // Width of a key index; a single key still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: 2-flop synchroniser, debounce counter, press/release
// pulses and the hold-to-repeat state machine.
module key_chan
  import key_pkg::*;
#(
  parameter int CNT_MAX    = CNT_MAX_DEF,
  parameter int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int REPEAT_PER = REPEAT_PER_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  input  logic repeat_en,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  logic [1:0]       sync;
  logic             s;
  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rcnt;
  rpt_state_e       rstate;

  // Two-flop synchroniser; idles at "released" so reset never looks like a press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) sync <= 2'b11;
    else            sync <= {sync[0], key_n};
  end

  assign s      = ~sync[1];
  // New level has been different from the debounced level for CNT_MAX+1 cycles.
  assign accept = (s != key_state) && (cnt == CNT_W'(CNT_MAX));

  // Debounce counter: any sample matching the current level restarts the count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      cnt         <= '0;
    end else begin
      key_press   <= accept &  s;
      key_release <= accept & ~s;
      if (s == key_state) begin
        cnt <= '0;
      end else if (accept) begin
        key_state <= s;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Auto-repeat: arm on the press pulse, drop out on release or when disabled.
  // Release is checked first so it beats a coincident terminal count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rstate     <= IDLE;
      rcnt       <= '0;
      key_repeat <= 1'b0;
    end else begin
      key_repeat <= 1'b0;
      if ((accept && !s) || !repeat_en) begin
        rstate <= IDLE;
        rcnt   <= '0;
      end else begin
        case (rstate)
          IDLE: begin
            if (accept && s) begin
              rstate <= DELAY;
              rcnt   <= '0;
            end
          end
          DELAY: begin
            if (rcnt == CNT_W'(REPEAT_DLY)) begin
              key_repeat <= 1'b1;
              rcnt       <= '0;
              rstate     <= REPEAT;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          REPEAT: begin
            if (rcnt == CNT_W'(REPEAT_PER)) begin
              key_repeat <= 1'b1;
              rcnt       <= '0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: begin
            rstate <= IDLE;
            rcnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/key_pad_debounce.sv
// N-channel push-button debouncer with press/release/repeat pulses and a
// registered merged event flag plus lowest-index key code.
module key_pad_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS     = 4,
  parameter int CNT_MAX    = CNT_MAX_DEF,
  parameter int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int REPEAT_PER = REPEAT_PER_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int IDX_W      = idx_w(N_KEYS)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [N_KEYS-1:0] key_n,
  input  logic              repeat_en,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              key_flag,
  output logic [IDX_W-1:0]  key_code
);

  logic [N_KEYS-1:0] evt;
  logic [IDX_W-1:0]  code_nxt;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_chan #(
      .CNT_MAX    (CNT_MAX),
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER),
      .CNT_W      (CNT_W)
    ) u_chan (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .key_n       (key_n[i]),
      .repeat_en   (repeat_en),
      .key_state   (key_state[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_repeat  (key_repeat[i])
    );
  end

  assign evt = key_press | key_repeat;

  // Priority encoder: scan high to low so the lowest active index wins.
  always_comb begin
    code_nxt = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (evt[i]) code_nxt = IDX_W'(i);
    end
  end

  // Merged flag/code, one cycle behind the pulses; code reads 0 when no event.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_flag <= 1'b0;
      key_code <= '0;
    end else begin
      key_flag <= |evt;
      key_code <= code_nxt;
    end
  end

endmodule
